stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 The module SHALL have parameter KEEP_WIDTH, default 3, giving the number of lanes per beat.
REQ-002 The module SHALL have parameter T_DATA_WIDTH, default 1, giving the bits per lane.
REQ-003 The module SHALL have parameter DEPTH, default 4, giving the beat entries; it SHALL be a power of 2 and at least 2.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port s_valid_i, input, 1 bit: upstream beat valid.
REQ-007 The module SHALL have port s_last_i, input, 1 bit: upstream beat is last of packet.
REQ-008 The module SHALL have port s_keep_i, input, KEEP_WIDTH bits: per-lane valid.
REQ-009 The module SHALL have port s_data_i, input, unpacked [KEEP_WIDTH] of T_DATA_WIDTH bits: lane data.
REQ-010 The module SHALL have port s_ready_o, output, 1 bit: FIFO accepts a beat.
REQ-011 The module SHALL have port m_valid_o, output, 1 bit: head beat available, toward the resizer slave port.
REQ-012 The module SHALL have port m_ready_i, input, 1 bit: downstream accepts the beat.
REQ-013 The module SHALL have output ports m_last_o (1 bit), m_keep_o (KEEP_WIDTH bits) and m_data_o ([KEEP_WIDTH] of T_DATA_WIDTH bits), carrying the head beat fields.
REQ-014 The module SHALL have port count_o, output, $clog2(DEPTH)+1 bits: stored beats.
REQ-015 The module SHALL have port pkt_count_o, output, $clog2(DEPTH)+1 bits: complete packets stored, i.e. stored beats with last=1.

Function
REQ-016 A push SHALL occur on a rising edge where s_valid_i=1 and s_ready_o=1; a pop SHALL occur on a rising edge where m_valid_o=1 and m_ready_i=1.
REQ-017 A push beat with s_keep_i=0 and s_last_i=0 (null beat) SHALL be accepted but not stored; pointers and counts SHALL be unchanged.
REQ-018 A push beat with s_keep_i=0 and s_last_i=1 SHALL be stored normally, so that packet end is preserved.
REQ-019 Storage SHALL be a DEPTH-entry circular array holding {last, keep, data}, with wr_ptr and rd_ptr each $clog2(DEPTH) bits wide, wrapping from DEPTH-1 to 0 without special handling.
REQ-020 s_ready_o SHALL be registered, and SHALL equal 1 exactly when count_o < DEPTH as updated by this edge's push and pop.
REQ-021 When full, s_ready_o=0 and no push SHALL occur, even if a pop occurs in the same cycle; there is no full-bypass.
REQ-022 m_valid_o SHALL be 1 exactly when count_o > 0.
REQ-023 m_last_o, m_keep_o and m_data_o SHALL present the entry at rd_ptr; when m_valid_o=0 they SHALL present m_last_o=0 and m_keep_o=0, with data don't-care.
REQ-024 First-word latency SHALL be 1 cycle: a beat pushed into an empty FIFO at edge N SHALL be presented with m_valid_o=1 after edge N.
REQ-025 There SHALL be no empty-bypass: a push and a pop SHALL never involve the same beat in one cycle.
REQ-026 While m_valid_o=1 and m_ready_i=0, all m_* outputs SHALL remain stable.
REQ-027 count_o SHALL update as follows: +1 on a storing push only, -1 on a pop only, unchanged on both or neither.
REQ-028 pkt_count_o SHALL update as follows: +1 on a storing push with last=1, -1 on a pop with last=1, unchanged when both or neither occur.
REQ-029 Simultaneous push and pop while 0 < count_o < DEPTH SHALL advance both pointers and keep count_o constant.
REQ-030 A pop when empty SHALL be impossible, since m_valid_o=0; m_ready_i SHALL be ignored while empty.
REQ-031 Beat order and field contents SHALL be preserved exactly from s_* to m_*.

Reset
REQ-032 While rst_n=0, the module SHALL hold wr_ptr=0, rd_ptr=0, count_o=0, pkt_count_o=0, m_valid_o=0, m_last_o=0, m_keep_o=0 and s_ready_o=0.
REQ-033 s_ready_o SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-034 Storage contents SHALL need no reset.
REQ-035 Assertion of rst_n mid-packet or mid-handshake SHALL immediately discard all stored beats, with no partial output after release.

Verification
REQ-036 Bench SHALL cover: reset release, then push 3 beats (keep=3'b111, 3'b011, 3'b001 with last=1) with m_ready_i=1 -> beats appear in order one cycle after each push; count_o peaks at 1; pkt_count_o pulses 0->1->0.
REQ-037 Bench SHALL cover: m_ready_i=0 and 5 push attempts with DEPTH=4 -> 4 accepted; s_ready_o=0 after the 4th; count_o=4; m_* stable.
REQ-038 Bench SHALL cover: full FIFO with m_ready_i=1 and s_valid_i=1 held -> no push on the pop cycle; s_ready_o=1 next cycle; count_o=3 then steady at 3 under continuous push/pop.
REQ-039 Bench SHALL cover: push keep=0,last=0 between two valid beats -> null beat absent at output; count_o never counts it.
REQ-040 Bench SHALL cover: push keep=0,last=1 -> appears on the output with m_last_o=1, m_keep_o=0; pkt_count_o increments then decrements.
REQ-041 Bench SHALL cover: rst_n=0 asserted asynchronously with count_o=3 mid-packet -> immediately m_valid_o=0, count_o=0, pkt_count_o=0, s_ready_o=0; s_ready_o=1 one edge after release.

Source files
------------

// File: rtl/stream_fifo.sv
// stream_fifo: a beat-wide FIFO for a keep-qualified stream. Each entry holds
// {last, keep, data[lanes]}. Beats with no valid lanes and no last flag are
// accepted but dropped. A keep=0 beat that carries last is still stored so the
// packet boundary survives. The FIFO also counts how many complete packets it
// holds. DEPTH must be a power of two, at least 2, so the pointers wrap
// naturally.
module stream_fifo #(
  parameter int KEEP_WIDTH   = 3,
  parameter int T_DATA_WIDTH = 1,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid_i,
  input  logic                    s_last_i,
  input  logic [KEEP_WIDTH-1:0]   s_keep_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [KEEP_WIDTH],
  output logic                    s_ready_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    m_last_o,
  output logic [KEEP_WIDTH-1:0]   m_keep_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [KEEP_WIDTH],
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [$clog2(DEPTH):0]  pkt_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic                    last_mem [DEPTH];
  logic [KEEP_WIDTH-1:0]   keep_mem [DEPTH];
  logic [T_DATA_WIDTH-1:0] data_mem [DEPTH][KEEP_WIDTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] pkt_count_q;
  logic [CW-1:0] count_next;
  logic [CW-1:0] pkt_count_next;
  logic          ready_q;

  logic push;
  logic store;
  logic pop;
  logic store_last;
  logic pop_last;

  // Handshake decode; a null beat (no lanes, no last) is accepted but not stored.
  always_comb begin
    push       = s_valid_i & ready_q;
    store      = push & ((|s_keep_i) | s_last_i);
    pop        = m_valid_o & m_ready_i;
    store_last = store & s_last_i;
    pop_last   = pop & last_mem[rd_ptr];
  end

  // Next beat and packet counts; simultaneous inc and dec cancel out.
  always_comb begin
    count_next     = count_q;
    pkt_count_next = pkt_count_q;
    if (store && !pop) begin
      count_next = count_q + CNT_ONE;
    end else if (!store && pop) begin
      count_next = count_q - CNT_ONE;
    end
    if (store_last && !pop_last) begin
      pkt_count_next = pkt_count_q + CNT_ONE;
    end else if (!store_last && pop_last) begin
      pkt_count_next = pkt_count_q - CNT_ONE;
    end
  end

  // Pointers, counts and the registered ready; ready stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q     <= count_next;
      pkt_count_q <= pkt_count_next;
      ready_q     <= (count_next < DEPTH_C);
    end
  end

  // Beat storage; contents are qualified by the counters so need no reset.
  always_ff @(posedge clk) begin
    if (store) begin
      last_mem[wr_ptr] <= s_last_i;
      keep_mem[wr_ptr] <= s_keep_i;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        data_mem[wr_ptr][i] <= s_data_i[i];
      end
    end
  end

  // Head-of-queue presentation; last/keep are forced low while empty.
  always_comb begin
    m_valid_o = (count_q != '0);
    m_last_o  = m_valid_o & last_mem[rd_ptr];
    m_keep_o  = m_valid_o ? keep_mem[rd_ptr] : '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      m_data_o[i] = data_mem[rd_ptr][i];
    end
  end

  assign s_ready_o   = ready_q;
  assign count_o     = count_q;
  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed table of per-cycle vectors with hand-computed
// expected outputs, plus hand-written reset sequences.
module tb_stream_fifo;

  logic       clk;
  logic       rst_n;
  logic       s_valid_i;
  logic       s_last_i;
  logic [2:0] s_keep_i;
  logic       s_data_i [3];
  logic       s_ready_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       m_last_o;
  logic [2:0] m_keep_o;
  logic       m_data_o [3];
  logic [2:0] count_o;
  logic [2:0] pkt_count_o;

  int vec_count  = 0;
  int fail_count = 0;

  typedef struct {
    logic       s_valid;
    logic       s_last;
    logic [2:0] s_keep;
    logic [2:0] s_data;
    logic       m_ready;
    logic       e_ready;
    logic       e_valid;
    logic       e_last;
    logic [2:0] e_keep;
    logic [2:0] e_data;
    logic [2:0] e_count;
    logic [2:0] e_pkt;
  } vec_t;

  vec_t vecs[$];

  stream_fifo #(.KEEP_WIDTH(3), .T_DATA_WIDTH(1), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_keep_i    (s_keep_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_last_o    (m_last_o),
    .m_keep_o    (m_keep_o),
    .m_data_o    (m_data_o),
    .count_o     (count_o),
    .pkt_count_o (pkt_count_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic sv, input logic sl, input logic [2:0] sk,
                              input logic [2:0] sd, input logic mr, input logic er,
                              input logic ev, input logic el, input logic [2:0] ek,
                              input logic [2:0] ed, input logic [2:0] ec,
                              input logic [2:0] ep);
    vec_t v;
    v.s_valid = sv; v.s_last = sl; v.s_keep = sk; v.s_data = sd; v.m_ready = mr;
    v.e_ready = er; v.e_valid = ev; v.e_last = el; v.e_keep = ek; v.e_data = ed;
    v.e_count = ec; v.e_pkt = ep;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    s_valid_i = v.s_valid;
    s_last_i  = v.s_last;
    s_keep_i  = v.s_keep;
    for (int i = 0; i < 3; i++) s_data_i[i] = v.s_data[i];
    m_ready_i = v.m_ready;
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    logic [2:0] act_data;
    logic       bad;
    for (int i = 0; i < 3; i++) act_data[i] = m_data_o[i];
    bad = (s_ready_o !== v.e_ready) || (m_valid_o !== v.e_valid) ||
          (m_last_o !== v.e_last) || (m_keep_o !== v.e_keep) ||
          (count_o !== v.e_count) || (pkt_count_o !== v.e_pkt) ||
          (v.e_valid && (act_data !== v.e_data));
    vec_count++;
    if (bad) begin
      fail_count++;
      $display("[TB] FAIL %s: got rdy=%b vld=%b last=%b keep=%b data=%b cnt=%0d pkt=%0d, want rdy=%b vld=%b last=%b keep=%b data=%b cnt=%0d pkt=%0d",
               name, s_ready_o, m_valid_o, m_last_o, m_keep_o, act_data, count_o, pkt_count_o,
               v.e_ready, v.e_valid, v.e_last, v.e_keep, v.e_data, v.e_count, v.e_pkt);
    end
  endtask

  // Drive one vector, let one edge pass, then check just after the edge.
  task automatic applyStimulus(input vec_t v, input string name);
    drive(v);
    @(posedge clk);
    #1;
    checkOutput(v, name);
  endtask

  vec_t idle;
  vec_t exp_rst;

  initial begin
    idle    = mk(0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
    exp_rst = idle;

    // in order, m_ready=1: each beat visible one edge after its push
    vecs.push_back(mk(1,0,3'b111,3'b101,1, 1,1,0,3'b111,3'b101,1,0));
    vecs.push_back(mk(1,0,3'b011,3'b010,1, 1,1,0,3'b011,3'b010,1,0));
    vecs.push_back(mk(1,1,3'b001,3'b001,1, 1,1,1,3'b001,3'b001,1,1));
    vecs.push_back(mk(0,0,3'b000,3'b000,1, 1,0,0,3'b000,3'b000,0,0));
    // fill with m_ready=0, fifth push refused, head stable
    vecs.push_back(mk(1,0,3'b111,3'b110,0, 1,1,0,3'b111,3'b110,1,0));
    vecs.push_back(mk(1,0,3'b010,3'b011,0, 1,1,0,3'b111,3'b110,2,0));
    vecs.push_back(mk(1,1,3'b100,3'b100,0, 1,1,0,3'b111,3'b110,3,1));
    vecs.push_back(mk(1,0,3'b001,3'b111,0, 0,1,0,3'b111,3'b110,4,1));
    vecs.push_back(mk(1,1,3'b111,3'b000,0, 0,1,0,3'b111,3'b110,4,1));
    // full, pop with push held: no push that cycle, then steady at 3
    vecs.push_back(mk(1,0,3'b011,3'b001,1, 1,1,0,3'b010,3'b011,3,1));
    vecs.push_back(mk(1,0,3'b011,3'b001,1, 1,1,1,3'b100,3'b100,3,1));
    vecs.push_back(mk(1,1,3'b110,3'b010,1, 1,1,0,3'b001,3'b111,3,1));
    vecs.push_back(mk(0,0,3'b000,3'b000,1, 1,1,0,3'b011,3'b001,2,1));
    vecs.push_back(mk(0,0,3'b000,3'b000,1, 1,1,1,3'b110,3'b010,1,1));
    vecs.push_back(mk(0,0,3'b000,3'b000,1, 1,0,0,3'b000,3'b000,0,0));
    // null beat between two real beats is dropped
    vecs.push_back(mk(1,0,3'b101,3'b101,0, 1,1,0,3'b101,3'b101,1,0));
    vecs.push_back(mk(1,0,3'b000,3'b111,0, 1,1,0,3'b101,3'b101,1,0));
    vecs.push_back(mk(1,1,3'b111,3'b011,0, 1,1,0,3'b101,3'b101,2,1));
    vecs.push_back(mk(0,0,3'b000,3'b000,1, 1,1,1,3'b111,3'b011,1,1));
    vecs.push_back(mk(0,0,3'b000,3'b000,1, 1,0,0,3'b000,3'b000,0,0));
    // keep=0 with last is stored and counted as a packet
    vecs.push_back(mk(1,1,3'b000,3'b000,0, 1,1,1,3'b000,3'b000,1,1));
    vecs.push_back(mk(0,0,3'b000,3'b000,1, 1,0,0,3'b000,3'b000,0,0));
    vecs.push_back(mk(0,0,3'b000,3'b000,1, 1,0,0,3'b000,3'b000,0,0));
    // three beats of an open packet, then async reset
    vecs.push_back(mk(1,0,3'b111,3'b001,0, 1,1,0,3'b111,3'b001,1,0));
    vecs.push_back(mk(1,0,3'b110,3'b100,0, 1,1,0,3'b111,3'b001,2,0));
    vecs.push_back(mk(1,0,3'b011,3'b011,0, 1,1,0,3'b111,3'b001,3,0));

    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    checkOutput(exp_rst, "reset_hold");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_rst.e_ready = 1'b1;
    checkOutput(exp_rst, "reset_release");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // async reset between edges with three beats held
    drive(idle);
    #3 rst_n = 1'b0;
    #1;
    exp_rst.e_ready = 1'b0;
    checkOutput(exp_rst, "async_reset");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_rst.e_ready = 1'b1;
    checkOutput(exp_rst, "after_async_release");
    applyStimulus(mk(0,0,3'b000,3'b000,1, 1,0,0,3'b000,3'b000,0,0), "no_stale_beat");
    applyStimulus(mk(1,1,3'b010,3'b010,0, 1,1,1,3'b010,3'b010,1,1), "push_after_reset");
    applyStimulus(mk(0,0,3'b000,3'b000,1, 1,0,0,3'b000,3'b000,0,0), "pop_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
